// File: rtl/muldiv_pkg.sv
// Shared constants for the HI/LO multiply/divide sequencer: state encodings,
// operation selects and the default operand width.
package muldiv_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/udiv_step.sv
// One combinational restoring-divide iteration on unsigned magnitudes:
// shift {rem, quot} left by one, trial-subtract the divisor, keep it if it fits.
module udiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quot_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_c_o,
    output logic [WIDTH-1:0] quot_c_o
);

    logic [WIDTH:0] shifted_c;
    logic [WIDTH:0] divisor_ext_c;
    logic           fits_c;

    assign shifted_c     = {rem_i, quot_i[WIDTH-1]};
    assign divisor_ext_c = {1'b0, divisor_i};
    assign fits_c        = (shifted_c >= divisor_ext_c);

    // rem < divisor before the shift, so the kept value always fits in WIDTH bits
    assign rem_c_o  = fits_c ? WIDTH'(shifted_c - divisor_ext_c) : shifted_c[WIDTH-1:0];
    assign quot_c_o = {quot_i[WIDTH-2:0], fits_c};

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle signed multiply/divide sequencer feeding the HI/LO registers.
// Shift-add multiply or restoring divide on magnitudes, then sign correction.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic             hilo_w_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CNT_W  = $clog2(WIDTH);
    localparam int unsigned PROD_W = 2 * WIDTH;

    state_e             state_q, state_d;
    logic               op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_dvd_q, neg_dvd_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   low_q, low_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;
    logic               hilo_w_q, hilo_w_d;

    logic [WIDTH-1:0]   mag_a_c;
    logic [WIDTH-1:0]   mag_b_c;
    logic [WIDTH:0]     mul_sum_c;
    logic [WIDTH-1:0]   div_rem_c;
    logic [WIDTH-1:0]   div_quot_c;
    logic [PROD_W-1:0]  prod_c;
    logic [PROD_W-1:0]  prod_neg_c;

    // Magnitudes; the most negative value maps onto its unsigned bit pattern
    assign mag_a_c = a_q[WIDTH-1] ? WIDTH'(-a_q) : a_q;
    assign mag_b_c = b_q[WIDTH-1] ? WIDTH'(-b_q) : b_q;

    assign mul_sum_c  = {1'b0, acc_q} + (low_q[0] ? {1'b0, opnd_q} : {(WIDTH + 1){1'b0}});
    assign prod_c     = {acc_q, low_q};
    assign prod_neg_c = PROD_W'(-prod_c);

    udiv_step #(
        .WIDTH     (WIDTH)
    ) u_step (
        .rem_i     (acc_q),
        .quot_i    (low_q),
        .divisor_i (opnd_q),
        .rem_c_o   (div_rem_c),
        .quot_c_o  (div_quot_c)
    );

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            op_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            neg_res_q  <= 1'b0;
            neg_dvd_q  <= 1'b0;
            acc_q      <= '0;
            low_q      <= '0;
            opnd_q     <= '0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hilo_w_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            neg_res_q  <= neg_res_d;
            neg_dvd_q  <= neg_dvd_d;
            acc_q      <= acc_d;
            low_q      <= low_d;
            opnd_q     <= opnd_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hilo_w_q   <= hilo_w_d;
        end
    end

    // Next-state, datapath and output strobes
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        neg_res_d  = neg_res_q;
        neg_dvd_d  = neg_dvd_q;
        acc_d      = acc_q;
        low_d      = low_q;
        opnd_d     = opnd_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = 1'b0;
        hilo_w_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    op_d      = op_i;
                    a_d       = a_i;
                    b_d       = b_i;
                    neg_res_d = a_i[WIDTH-1] ^ b_i[WIDTH-1];
                    neg_dvd_d = a_i[WIDTH-1];
                    state_d   = ST_PREP;
                end
            end
            ST_PREP: begin
                // Multiply is commutative, so both ops load |a| into the low half
                acc_d  = '0;
                low_d  = mag_a_c;
                opnd_d = mag_b_c;
                cnt_d  = CNT_W'(WIDTH - 1);
                if ((op_q == OP_DIV) && (b_q == '0)) begin
                    div_zero_d = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (op_q == OP_MULT) begin
                    acc_d = mul_sum_c[WIDTH:1];
                    low_d = {mul_sum_c[0], low_q[WIDTH-1:1]};
                end else begin
                    acc_d = div_rem_c;
                    low_d = div_quot_c;
                end
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FIX: begin
                if (op_q == OP_MULT) begin
                    {hi_d, lo_d} = neg_res_q ? prod_neg_c : prod_c;
                end else begin
                    // Truncating division: remainder follows the dividend's sign
                    lo_d = neg_res_q ? WIDTH'(-low_q) : low_q;
                    hi_d = neg_dvd_q ? WIDTH'(-acc_q) : acc_q;
                end
                hilo_w_d = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign div_zero_o = div_zero_q;
    assign hilo_w_o   = hilo_w_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: expected results are queued when an op is
// started and popped/compared when done pulses.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int unsigned W = DEFAULT_WIDTH;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        bit           dz;
        int           lat;
    } exp_t;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         start_i;
    logic         op_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         busy_o;
    logic         done_o;
    logic         div_zero_o;
    logic         hilo_w_o;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;

    int           vectors;
    int           miscompares;
    exp_t         sbq[$];
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .op_i       (op_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .div_zero_o (div_zero_o),
        .hilo_w_o   (hilo_w_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit signed arithmetic, C-style truncating division
    function automatic exp_t model(input logic op_v, input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t   e;
        longint sa, sbv, p, q, r;
        sa    = longint'($signed(av));
        sbv   = longint'($signed(bv));
        e.dz  = 1'b0;
        e.lat = 35;
        if (op_v == OP_MULT) begin
            p    = sa * sbv;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (bv == '0) begin
            e.dz  = 1'b1;
            e.lat = 2;
            e.hi  = m_hi;
            e.lo  = m_lo;
        end else begin
            q    = sa / sbv;
            r    = sa % sbv;
            e.hi = r[31:0];
            e.lo = q[31:0];
        end
        return e;
    endfunction

    // Called at a falling edge with the DUT idle; returns at the falling edge after DONE
    task automatic run_op(input logic op_v, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input bit inject, input string name);
        exp_t e;
        int   k;
        int   bc;
        bit   seen;
        chk({name, "/busy_at_start"}, 64'(busy_o), 64'(0));
        sbq.push_back(model(op_v, av, bv));
        op_i    = op_v;
        a_i     = av;
        b_i     = bv;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        op_i    = ~op_v;
        a_i     = $urandom;
        b_i     = $urandom;
        bc      = 0;
        seen    = 1'b0;
        for (k = 1; k <= 60; k++) begin
            if (k == 1) chk({name, "/busy_first"}, 64'(busy_o), 64'(1));
            if (busy_o) bc++;
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            start_i = inject && (k == 10);
            @(negedge clk_i);
        end
        e = sbq.pop_front();
        chk({name, "/latency"}, 64'(seen ? k : -1), 64'(e.lat));
        chk({name, "/busy_cycles"}, 64'(bc), 64'(e.lat));
        chk({name, "/hi"}, 64'(hi_o), 64'(e.hi));
        chk({name, "/lo"}, 64'(lo_o), 64'(e.lo));
        chk({name, "/hilo_w"}, 64'(hilo_w_o), 64'(!e.dz));
        chk({name, "/div_zero"}, 64'(div_zero_o), 64'(e.dz));
        if (!e.dz) begin
            m_hi = e.hi;
            m_lo = e.lo;
        end
        start_i = inject;
        @(negedge clk_i);
        start_i = 1'b0;
        chk({name, "/done_pulse"}, 64'(done_o), 64'(0));
        chk({name, "/busy_after"}, 64'(busy_o), 64'(0));
    endtask

    initial begin
        int dones;
        vectors     = 0;
        miscompares = 0;
        m_hi        = '0;
        m_lo        = '0;
        reset_i     = 1'b1;
        start_i     = 1'b0;
        op_i        = OP_MULT;
        a_i         = '0;
        b_i         = '0;
        repeat (3) @(negedge clk_i);
        chk("rst/busy", 64'(busy_o), 64'(0));
        chk("rst/done", 64'(done_o), 64'(0));
        chk("rst/div_zero", 64'(div_zero_o), 64'(0));
        chk("rst/hilo_w", 64'(hilo_w_o), 64'(0));
        chk("rst/hi", 64'(hi_o), 64'(0));
        chk("rst/lo", 64'(lo_o), 64'(0));
        reset_i = 1'b0;
        @(negedge clk_i);

        run_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, 1'b0, "mul_7_m3");
        chk("mul_7_m3/hi_const", 64'(m_hi), 64'h0000_0000_FFFF_FFFF);
        chk("mul_7_m3/lo_const", 64'(m_lo), 64'h0000_0000_FFFF_FFEB);
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, "mul_min_min");
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, "div_7_m2");
        run_op(OP_DIV, 32'd5, 32'd0, 1'b0, "div_by_zero");
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_overflow");
        run_op(OP_MULT, 32'd123456, 32'hFFFE_7E33, 1'b1, "mul_ignored_starts");
        run_op(OP_DIV, 32'd1000, 32'd7, 1'b0, "div_back_to_back");
        for (int i = 0; i < 6; i++) begin
            run_op(1'($urandom_range(0, 1)), $urandom,
                   ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom,
                   1'b0, "random");
        end

        // Reset in the middle of a divide
        op_i    = OP_DIV;
        a_i     = 32'd1000;
        b_i     = 32'd3;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (19) @(negedge clk_i);
        chk("midrst/busy_before", 64'(busy_o), 64'(1));
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        chk("midrst/busy", 64'(busy_o), 64'(0));
        chk("midrst/hi", 64'(hi_o), 64'(0));
        chk("midrst/lo", 64'(lo_o), 64'(0));
        chk("midrst/hilo_w", 64'(hilo_w_o), 64'(0));
        m_hi  = '0;
        m_lo  = '0;
        dones = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (done_o || hilo_w_o) dones++;
        end
        chk("midrst/no_done", 64'(dones), 64'(0));

        // Reset and start together: the start is dropped
        reset_i = 1'b1;
        start_i = 1'b1;
        op_i    = OP_MULT;
        a_i     = 32'd9;
        b_i     = 32'd9;
        @(negedge clk_i);
        reset_i = 1'b0;
        start_i = 1'b0;
        chk("rst_start/busy0", 64'(busy_o), 64'(0));
        @(negedge clk_i);
        chk("rst_start/busy1", 64'(busy_o), 64'(0));

        run_op(OP_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 1'b0, "mul_m5_m6");
        run_op(OP_DIV, 32'd5, 32'd0, 1'b0, "div_zero_keep");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
